tl_async_crossing_sink: RTL and testbench

- Receiving end of a depth-1 TileLink asynchronous crossing.
- A side: accepts A beats from a remote crossing source through a one-entry async queue (payload register plus a Gray index) and presents them as a ready/valid A channel.
- D side: accepts D responses on a ready/valid channel and publishes them into a one-entry async queue back to the remote source.
- All logic runs in the local clock domain. Remote index and alive signals are brought in through internal 3-flop synchronizers.

---
 rtl/tl_async_crossing_sink.sv | 116 +++++++++++
 tb/tb_tl_async_crossing_sink.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_async_crossing_sink.sv
// tl_async_crossing_sink: receive side of a depth-1 TileLink async crossing (A beats in, D responses out)
module tl_async_crossing_sink #(
  parameter int SYNC_DEPTH = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  auto_in_a_mem_0_opcode,
  input  logic [2:0]  auto_in_a_mem_0_param,
  input  logic [1:0]  auto_in_a_mem_0_size,
  input  logic        auto_in_a_mem_0_source,
  input  logic [8:0]  auto_in_a_mem_0_address,
  input  logic [3:0]  auto_in_a_mem_0_mask,
  input  logic [31:0] auto_in_a_mem_0_data,
  input  logic        auto_in_a_mem_0_corrupt,
  input  logic        auto_in_a_widx,
  input  logic        auto_in_a_safe_widx_valid,
  input  logic        auto_in_a_safe_source_reset_n,
  output logic        auto_in_a_ridx,
  output logic        auto_in_a_safe_ridx_valid,
  output logic        auto_in_a_safe_sink_reset_n,
  input  logic        auto_out_a_ready,
  output logic        auto_out_a_valid,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [1:0]  auto_out_a_bits_size,
  output logic        auto_out_a_bits_source,
  output logic [8:0]  auto_out_a_bits_address,
  output logic [3:0]  auto_out_a_bits_mask,
  output logic [31:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [1:0]  auto_out_d_bits_size,
  input  logic        auto_out_d_bits_source,
  input  logic        auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [31:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt,
  output logic        auto_out_d_ready,
  output logic [2:0]  auto_in_d_mem_0_opcode,
  output logic [1:0]  auto_in_d_mem_0_param,
  output logic [1:0]  auto_in_d_mem_0_size,
  output logic        auto_in_d_mem_0_source,
  output logic        auto_in_d_mem_0_sink,
  output logic        auto_in_d_mem_0_denied,
  output logic [31:0] auto_in_d_mem_0_data,
  output logic        auto_in_d_mem_0_corrupt,
  output logic        auto_in_d_widx,
  output logic        auto_in_d_safe_widx_valid,
  output logic        auto_in_d_safe_source_reset_n,
  input  logic        auto_in_d_ridx,
  input  logic        auto_in_d_safe_ridx_valid,
  input  logic        auto_in_d_safe_sink_reset_n
);
  logic local_alive, a_ridx, a_valid, d_widx;
  logic [SYNC_DEPTH-1:0] a_widx_sync, a_alive_sync, d_ridx_sync, d_alive_sync;
  logic [54:0] a_q;
  logic [42:0] d_q;
  logic a_src_alive_s, d_sink_alive_s, a_pending, a_fire, d_fire;
  assign a_src_alive_s = a_alive_sync[SYNC_DEPTH-1];
  assign d_sink_alive_s = d_alive_sync[SYNC_DEPTH-1];
  assign a_pending = a_src_alive_s & (a_widx_sync[SYNC_DEPTH-1] != a_ridx);
  assign a_fire = a_valid & auto_out_a_ready;
  assign auto_out_d_ready = local_alive & d_sink_alive_s & (d_widx == d_ridx_sync[SYNC_DEPTH-1]);
  assign d_fire = auto_out_d_valid & auto_out_d_ready;
  assign auto_in_a_ridx = a_ridx;
  assign auto_in_a_safe_ridx_valid = local_alive & a_src_alive_s;
  assign auto_in_a_safe_sink_reset_n = local_alive;
  assign auto_out_a_valid = a_valid;
  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size, auto_out_a_bits_source,
          auto_out_a_bits_address, auto_out_a_bits_mask, auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_q;
  assign {auto_in_d_mem_0_opcode, auto_in_d_mem_0_param, auto_in_d_mem_0_size, auto_in_d_mem_0_source,
          auto_in_d_mem_0_sink, auto_in_d_mem_0_denied, auto_in_d_mem_0_data, auto_in_d_mem_0_corrupt} = d_q;
  assign auto_in_d_widx = d_widx;
  assign auto_in_d_safe_widx_valid = local_alive & d_sink_alive_s;
  assign auto_in_d_safe_source_reset_n = local_alive;
  always_ff @(posedge clock) begin
    if (reset) begin
      local_alive <= 1'b0;
      a_widx_sync <= '0;
      a_alive_sync <= '0;
      d_ridx_sync <= '0;
      d_alive_sync <= '0;
      a_ridx <= 1'b0;
      a_valid <= 1'b0;
      a_q <= '0;
      d_widx <= 1'b0;
      d_q <= '0;
    end else begin
      local_alive <= 1'b1;
      a_alive_sync <= {a_alive_sync[SYNC_DEPTH-2:0], auto_in_a_safe_source_reset_n & auto_in_a_safe_widx_valid};
      d_alive_sync <= {d_alive_sync[SYNC_DEPTH-2:0], auto_in_d_safe_sink_reset_n & auto_in_d_safe_ridx_valid};
      d_ridx_sync <= {d_ridx_sync[SYNC_DEPTH-2:0], auto_in_d_ridx};
      // a dead remote source flushes its stale index so a revived source starts clean
      a_widx_sync <= a_src_alive_s ? {a_widx_sync[SYNC_DEPTH-2:0], auto_in_a_widx} : '0;
      if (!a_src_alive_s) begin
        a_valid <= 1'b0;
        a_ridx <= 1'b0;
      end else if (a_fire) begin
        a_valid <= 1'b0;
        a_ridx <= ~a_ridx;
      end else if (a_pending && !a_valid) begin
        a_valid <= 1'b1;
        a_q <= {auto_in_a_mem_0_opcode, auto_in_a_mem_0_param, auto_in_a_mem_0_size, auto_in_a_mem_0_source,
                auto_in_a_mem_0_address, auto_in_a_mem_0_mask, auto_in_a_mem_0_data, auto_in_a_mem_0_corrupt};
      end
      if (!d_sink_alive_s) d_widx <= 1'b0;
      else if (d_fire) begin
        d_widx <= ~d_widx;
        d_q <= {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size, auto_out_d_bits_source,
                auto_out_d_bits_sink, auto_out_d_bits_denied, auto_out_d_bits_data, auto_out_d_bits_corrupt};
      end
    end
  end
endmodule

// File: tb/tb_tl_async_crossing_sink.sv
// tb_tl_async_crossing_sink: directed vector table, remote-reset sequences and randomized traffic vs a transaction model
module tb_tl_async_crossing_sink;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic [54:0] a_mem;
  logic a_widx, a_wv, a_srn, a_ready;
  wire a_ridx, a_rv, a_sink_rn, a_valid;
  wire [54:0] a_bits;
  logic d_valid, d_ridx, d_rv, d_snk;
  logic [42:0] d_bits;
  wire d_ready, d_widx, d_wv, d_src_rn;
  wire [42:0] d_mem;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct { logic [54:0] a; int hold; bit d_en; int d_at; logic [42:0] d; } vec_t;
  typedef struct { logic [54:0] p; int t; } abeat_t;
  vec_t tv[5];
  abeat_t aq[$];
  logic a_w, ar, dw, dfire, a_vx, d_rx, af, df;
  logic [42:0] d_sb;
  logic [63:0] r64;
  int total, t_r;

  tl_async_crossing_sink #(.SYNC_DEPTH(3)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_mem_0_opcode(a_mem[54:52]), .auto_in_a_mem_0_param(a_mem[51:49]),
    .auto_in_a_mem_0_size(a_mem[48:47]), .auto_in_a_mem_0_source(a_mem[46]),
    .auto_in_a_mem_0_address(a_mem[45:37]), .auto_in_a_mem_0_mask(a_mem[36:33]),
    .auto_in_a_mem_0_data(a_mem[32:1]), .auto_in_a_mem_0_corrupt(a_mem[0]),
    .auto_in_a_widx(a_widx), .auto_in_a_safe_widx_valid(a_wv), .auto_in_a_safe_source_reset_n(a_srn),
    .auto_in_a_ridx(a_ridx), .auto_in_a_safe_ridx_valid(a_rv), .auto_in_a_safe_sink_reset_n(a_sink_rn),
    .auto_out_a_ready(a_ready), .auto_out_a_valid(a_valid),
    .auto_out_a_bits_opcode(a_bits[54:52]), .auto_out_a_bits_param(a_bits[51:49]),
    .auto_out_a_bits_size(a_bits[48:47]), .auto_out_a_bits_source(a_bits[46]),
    .auto_out_a_bits_address(a_bits[45:37]), .auto_out_a_bits_mask(a_bits[36:33]),
    .auto_out_a_bits_data(a_bits[32:1]), .auto_out_a_bits_corrupt(a_bits[0]),
    .auto_out_d_valid(d_valid),
    .auto_out_d_bits_opcode(d_bits[42:40]), .auto_out_d_bits_param(d_bits[39:38]),
    .auto_out_d_bits_size(d_bits[37:36]), .auto_out_d_bits_source(d_bits[35]),
    .auto_out_d_bits_sink(d_bits[34]), .auto_out_d_bits_denied(d_bits[33]),
    .auto_out_d_bits_data(d_bits[32:1]), .auto_out_d_bits_corrupt(d_bits[0]),
    .auto_out_d_ready(d_ready),
    .auto_in_d_mem_0_opcode(d_mem[42:40]), .auto_in_d_mem_0_param(d_mem[39:38]),
    .auto_in_d_mem_0_size(d_mem[37:36]), .auto_in_d_mem_0_source(d_mem[35]),
    .auto_in_d_mem_0_sink(d_mem[34]), .auto_in_d_mem_0_denied(d_mem[33]),
    .auto_in_d_mem_0_data(d_mem[32:1]), .auto_in_d_mem_0_corrupt(d_mem[0]),
    .auto_in_d_widx(d_widx), .auto_in_d_safe_widx_valid(d_wv), .auto_in_d_safe_source_reset_n(d_src_rn),
    .auto_in_d_ridx(d_ridx), .auto_in_d_safe_ridx_valid(d_rv), .auto_in_d_safe_sink_reset_n(d_snk)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic d_send(input logic [42:0] b);
    d_bits = b;
    d_valid = 1'b1;
    chk("d_ready_pre", d_ready, 1'b1);
    step;
    d_valid = 1'b0;
    dw = ~dw;
    chk("d_mem", d_mem, b);
    chk("d_widx", d_widx, dw);
    chk("d_ready_post", d_ready, 1'b0);
  endtask

  initial begin
    tv[0] = '{{3'd4, 3'd0, 2'd2, 1'b0, 9'h1A4, 4'hF, 32'hDEADBEEF, 1'b0}, 0, 1'b0, 0, 43'd0};
    tv[1] = '{{3'd4, 3'd0, 2'd2, 1'b0, 9'h1A4, 4'hF, 32'hDEADBEEF, 1'b0}, 6, 1'b0, 0, 43'd0};
    tv[2] = '{{3'd1, 3'd2, 2'd1, 1'b1, 9'h0F3, 4'h3, 32'hA5A5_0001, 1'b1}, 0, 1'b1, 1,
              {3'd1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0}};
    tv[3] = '{{3'd0, 3'd7, 2'd3, 1'b0, 9'h1FF, 4'h8, 32'h0000_FFFF, 1'b0}, 2, 1'b1, 4,
              {3'd5, 2'd3, 2'd1, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1}};
    tv[4] = '{{3'd6, 3'd1, 2'd0, 1'b1, 9'h001, 4'h1, 32'h8000_0000, 1'b1}, 0, 1'b1, 5,
              {3'd2, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0}};
    a_mem = '0; a_widx = 1'b0; a_wv = 1'b1; a_srn = 1'b1; a_ready = 1'b0;
    d_valid = 1'b0; d_bits = '0; d_ridx = 1'b0; d_rv = 1'b1; d_snk = 1'b1;
    a_w = 1'b0; ar = 1'b0; dw = 1'b0;
    repeat (5) step;
    chk("rst_a_outputs", {a_ridx, a_rv, a_sink_rn, a_valid, a_bits}, 64'd0);
    chk("rst_d_outputs", {d_ready, d_widx, d_wv, d_src_rn, d_mem}, 64'd0);
    reset = 1'b0;
    step;
    chk("alive_reset_n", {a_sink_rn, d_src_rn}, 2'b11);
    step;
    step;
    chk("alive_valid", {a_rv, d_wv, d_ready}, 3'b111);
    for (int i = 0; i < 5; i++) begin
      total = 5 + tv[i].hold;
      a_mem = tv[i].a;
      a_w = ~a_w;
      a_widx = a_w;
      for (int k = 1; k <= total; k++) begin
        dfire = tv[i].d_en && k == tv[i].d_at;
        if (dfire) begin
          d_bits = tv[i].d;
          d_valid = 1'b1;
          chk("d_ready_pre", d_ready, 1'b1);
        end
        a_ready = (tv[i].hold == 0) || k == total;
        step;
        d_valid = 1'b0;
        if (dfire) begin
          dw = ~dw;
          chk("d_mem", d_mem, tv[i].d);
          chk("d_widx", d_widx, dw);
          chk("d_ready_post", d_ready, 1'b0);
        end
        if (k == total) ar = ~ar;
        chk("a_valid", a_valid, k >= 4 && k < total);
        if (k >= 4 && k < total) chk("a_bits", a_bits, tv[i].a);
        chk("a_ridx", a_ridx, ar);
      end
      a_ready = 1'b0;
      if (tv[i].d_en) begin
        d_ridx = dw;
        step;
        step;
        chk("d_ready_wait", d_ready, 1'b0);
        step;
        chk("d_ready_back", d_ready, 1'b1);
      end
    end
    // remote A source resets while a beat is presented and unaccepted
    a_mem = tv[3].a;
    a_w = ~a_w;
    a_widx = a_w;
    repeat (4) step;
    chk("adrop_valid_before", a_valid, 1'b1);
    chk("adrop_ridx_before", a_ridx, ar);
    a_srn = 1'b0;
    a_w = 1'b0;
    a_widx = 1'b0;
    repeat (4) step;
    ar = 1'b0;
    chk("adrop_valid", a_valid, 1'b0);
    chk("adrop_ridx", a_ridx, 1'b0);
    chk("adrop_rv", a_rv, 1'b0);
    a_srn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step;
      chk("arevive_no_beat", a_valid, 1'b0);
    end
    chk("arevive_rv", a_rv, 1'b1);
    a_mem = tv[4].a;
    a_w = 1'b1;
    a_widx = 1'b1;
    repeat (4) step;
    chk("arevive_valid", a_valid, 1'b1);
    chk("arevive_bits", a_bits, tv[4].a);
    a_ready = 1'b1;
    step;
    ar = 1'b1;
    chk("arevive_fire", {a_valid, a_ridx}, 2'b01);
    a_ready = 1'b0;
    // remote D sink resets with a response outstanding
    d_send(tv[3].d);
    d_ridx = dw;
    repeat (3) step;
    if (dw == 1'b0) d_send(tv[2].d);
    chk("ddrop_widx_before", d_widx, 1'b1);
    d_snk = 1'b0;
    d_ridx = 1'b0;
    repeat (4) step;
    dw = 1'b0;
    chk("ddrop_state", {d_widx, d_ready, d_wv}, 3'b000);
    d_snk = 1'b1;
    repeat (3) step;
    chk("drevive_state", {d_ready, d_wv}, 2'b11);
    t_r = cyc - 10;
    // random traffic on both channels against a transaction-level model
    for (int n = 0; n < 3000; n++) begin
      a_ready = 1'($urandom_range(0, 1));
      if (aq.size() == 0 && $urandom_range(0, 3) == 0) begin
        r64 = {$urandom, $urandom};
        a_mem = r64[54:0];
        a_w = ~a_w;
        a_widx = a_w;
        aq.push_back('{a_mem, cyc});
      end
      if (dw != d_ridx && $urandom_range(0, 3) == 0) begin
        chk("rnd_d_mem", d_mem, d_sb);
        d_ridx = dw;
        t_r = cyc;
      end
      d_valid = 1'($urandom_range(0, 1));
      r64 = {$urandom, $urandom};
      d_bits = r64[42:0];
      a_vx = aq.size() > 0 && cyc >= aq[0].t + 4;
      d_rx = dw == d_ridx && cyc >= t_r + 3;
      chk("rnd_a_valid", a_valid, a_vx);
      if (a_vx) chk("rnd_a_bits", a_bits, aq[0].p);
      chk("rnd_a_ridx", a_ridx, ar);
      chk("rnd_d_ready", d_ready, d_rx);
      af = a_vx && a_ready;
      df = d_valid && d_rx;
      step;
      if (af) begin
        void'(aq.pop_front());
        ar = ~ar;
      end
      if (df) begin
        dw = ~dw;
        d_sb = d_bits;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
